// File: rtl/lcd_bus_responder.sv
// Responder side of an HD44780-style 8-bit character-LCD bus.
// Samples E in the clk domain, acts on each E falling edge, and keeps the
// 80-byte DDRAM, the address counter, the display shift and the mode flags.
// DDRAM contents are exposed through a registered view port for mirrors.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [6:0] view_addr,
    output logic [7:0] view_char,
    output logic [6:0] ac,
    output logic [5:0] disp_shift,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       shift_mode,
    output logic       two_line,
    output logic       eight_bit,
    output logic       busy,
    output logic       overrun,
    output logic       err_illegal
);

    typedef enum logic [1:0] {FILL, WAIT, IDLE} state_t;

    typedef struct packed {
        logic disp_on;
        logic cursor_on;
        logic blink_on;
        logic inc_mode;
        logic shift_mode;
        logic two_line;
        logic eight_bit;
    } mode_t;

    localparam logic [6:0] LAST_IDX = 7'd79;

    // AC is legal if it points at a visible DDRAM cell in the current line mode.
    function automatic logic ac_legal(input logic [6:0] a, input logic two);
        if (two) return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        return a <= 7'h4F;
    endfunction

    // Line-2 addresses (0x40..0x67) map onto linear cells 40..79.
    function automatic logic [6:0] ac_index(input logic [6:0] a, input logic two);
        if (two && a[6]) return a - 7'd24;
        return a;
    endfunction

    // Step the address counter by one, wrapping across the line gaps.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic two, input logic up);
        if (two) begin
            if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end
        if (up) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    // Display shift is a position on a 40-column ring.
    function automatic logic [5:0] shift_step(input logic [5:0] d, input logic up);
        if (up) return (d == 6'd39) ? 6'd0 : d + 6'd1;
        return (d == 6'd0) ? 6'd39 : d - 6'd1;
    endfunction

    logic [7:0]  mem [80];
    state_t      state, state_n;
    mode_t       mode, mode_n;
    logic [6:0]  fill_idx, fill_n;
    logic [15:0] wait_cnt, wait_n;
    logic [6:0]  ac_n;
    logic [5:0]  shift_n;
    logic        overrun_n, err_n, rd_valid_n;
    logic [7:0]  rd_data_n;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata;

    logic        e_s1, e_s2, rs_q, rw_q;
    logic [7:0]  data_q;
    logic        cap_rs, cap_rw;
    logic [7:0]  cap_data;
    logic        e_fall, filling;

    assign e_fall  = e_s2 & ~e_s1;
    assign filling = (state != IDLE);
    // Held reset reports not-busy; the fill itself starts on release.
    assign busy    = rst & filling;

    assign disp_on    = mode.disp_on;
    assign cursor_on  = mode.cursor_on;
    assign blink_on   = mode.blink_on;
    assign inc_mode   = mode.inc_mode;
    assign shift_mode = mode.shift_mode;
    assign two_line   = mode.two_line;
    assign eight_bit  = mode.eight_bit;

    // Synchronise E and capture the bus fields seen while E was high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            e_s1     <= 1'b0;
            e_s2     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= 8'h00;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else begin
            e_s1   <= lcd_e;
            e_s2   <= e_s1;
            rs_q   <= lcd_rs;
            rw_q   <= lcd_rw;
            data_q <= lcd_data;
            if (e_s1) begin
                cap_rs   <= rs_q;
                cap_rw   <= rw_q;
                cap_data <= data_q;
            end
        end
    end

    // Next-state logic: fill/wait sequencing plus transaction decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n    = state;
        fill_n     = fill_idx;
        wait_n     = wait_cnt;
        ac_n       = ac;
        shift_n    = disp_shift;
        mode_n     = mode;
        overrun_n  = overrun;
        err_n      = err_illegal;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = fill_idx;
        mem_wdata  = 8'h20;

        case (state)
            FILL: begin
                mem_we = 1'b1;
                if (fill_idx == LAST_IDX) begin
                    fill_n  = 7'd0;
                    state_n = IDLE;
                    if (BUSY_CYCLES > 0) begin
                        state_n = WAIT;
                        wait_n  = 16'(BUSY_CYCLES - 1);
                    end
                end else begin
                    fill_n = fill_idx + 7'd1;
                end
            end
            WAIT: begin
                if (wait_cnt == 16'd0) state_n = IDLE;
                else                   wait_n  = wait_cnt - 16'd1;
            end
            IDLE:    ;
            default: state_n = IDLE;
        endcase

        if (e_fall) begin
            if (cap_rw) begin
                rd_valid_n = 1'b1;
                if (!cap_rs) begin
                    rd_data_n = {filling, ac};
                end else if (filling) begin
                    rd_data_n = 8'h00;
                end else begin
                    rd_data_n = ac_legal(ac, mode.two_line) ? mem[ac_index(ac, mode.two_line)] : 8'h00;
                    ac_n      = ac_step(ac, mode.two_line, mode.inc_mode);
                end
            end else if (filling) begin
                overrun_n = 1'b1;
            end else begin
                if (BUSY_CYCLES > 0) begin
                    state_n = WAIT;
                    wait_n  = 16'(BUSY_CYCLES - 1);
                end
                if (cap_rs) begin
                    if (ac_legal(ac, mode.two_line)) begin
                        mem_we    = 1'b1;
                        mem_addr  = ac_index(ac, mode.two_line);
                        mem_wdata = cap_data;
                    end else begin
                        err_n = 1'b1;
                    end
                    ac_n = ac_step(ac, mode.two_line, mode.inc_mode);
                    if (mode.shift_mode) shift_n = shift_step(disp_shift, mode.inc_mode);
                end else begin
                    casez (cap_data)
                        8'b1???????: begin
                            if (ac_legal(cap_data[6:0], mode.two_line)) ac_n = cap_data[6:0];
                            else                                      err_n = 1'b1;
                        end
                        8'b01??????: err_n = 1'b1;
                        8'b001?????: begin
                            mode_n.eight_bit = cap_data[4];
                            mode_n.two_line  = cap_data[3];
                        end
                        8'b0001????: begin
                            if (cap_data[3]) shift_n = shift_step(disp_shift, cap_data[2]);
                            else             ac_n    = ac_step(ac, mode.two_line, cap_data[2]);
                        end
                        8'b00001???: begin
                            mode_n.disp_on   = cap_data[2];
                            mode_n.cursor_on = cap_data[1];
                            mode_n.blink_on  = cap_data[0];
                        end
                        8'b000001??: begin
                            mode_n.inc_mode   = cap_data[1];
                            mode_n.shift_mode = cap_data[0];
                        end
                        8'b0000001?: begin
                            ac_n    = 7'd0;
                            shift_n = 6'd0;
                        end
                        8'b00000001: begin
                            ac_n            = 7'd0;
                            shift_n         = 6'd0;
                            mode_n.inc_mode = 1'b1;
                            state_n         = FILL;
                            fill_n          = 7'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FILL;
            fill_idx    <= 7'd0;
            wait_cnt    <= 16'd0;
            ac          <= 7'd0;
            disp_shift  <= 6'd0;
            mode        <= '{disp_on: 1'b0, cursor_on: 1'b0, blink_on: 1'b0, inc_mode: 1'b1,
                             shift_mode: 1'b0, two_line: 1'b0, eight_bit: 1'b1};
            overrun     <= 1'b0;
            err_illegal <= 1'b0;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
        end else begin
            state       <= state_n;
            fill_idx    <= fill_n;
            wait_cnt    <= wait_n;
            ac          <= ac_n;
            disp_shift  <= shift_n;
            mode        <= mode_n;
            overrun     <= overrun_n;
            err_illegal <= err_n;
            rd_data     <= rd_data_n;
            rd_valid    <= rd_valid_n;
        end
    end

    // DDRAM write port and registered view read port.
    always_ff @(posedge clk) begin
        // NOTE: the DDRAM array has no reset; the FILL sequence initialises it after every reset.
        if (mem_we) mem[mem_addr] <= mem_wdata;
        view_char <= (view_addr > LAST_IDX) ? 8'h20 : mem[view_addr];
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: drives E/RS/RW/DATA bus cycles,
// tracks the expected display state in a linear-index model and compares.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [6:0] view_addr;
    logic [7:0] view_char;
    logic [6:0] ac;
    logic [5:0] disp_shift;
    logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line, eight_bit;
    logic       busy, overrun, err_illegal;

    always #5 clk = ~clk;

    lcd_bus_responder #(.BUSY_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .view_addr(view_addr), .view_char(view_char), .ac(ac), .disp_shift(disp_shift),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode),
        .shift_mode(shift_mode), .two_line(two_line), .eight_bit(eight_bit),
        .busy(busy), .overrun(overrun), .err_illegal(err_illegal)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model: display as 80 linear cells ----------------
    logic [7:0] m_mem [80];
    logic [6:0] m_ac;
    int         m_ds;
    bit m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_eight, m_ovr, m_err, m_busy;

    function automatic int lin(input logic [6:0] a);
        if (m_two && a >= 7'h40) return int'(a) - 64 + 40;
        return int'(a);
    endfunction

    function automatic logic [6:0] unlin(input int i);
        if (m_two && i >= 40) return 7'(i - 40 + 64);
        return 7'(i);
    endfunction

    // Both modes expose 80 cells, so a step is just +/-1 mod 80 on the linear index.
    function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
        return unlin((lin(a) + (up ? 1 : 79)) % 80);
    endfunction

    function automatic bit m_legal(input logic [6:0] a);
        if (m_two) return (a < 7'd40) || (a >= 7'd64 && a < 7'd104);
        return a < 7'd80;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 7'd0; m_ds = 0;
        m_disp = 0; m_cur = 0; m_blink = 0; m_shift = 0; m_two = 0;
        m_inc = 1; m_eight = 1; m_ovr = 0; m_err = 0; m_busy = 1;
    endtask

    task automatic model_txn(input bit rs, input bit rw, input logic [7:0] d, output logic [7:0] exp_rd);
        exp_rd = 8'h00;
        if (rw) begin
            if (!rs) exp_rd = {m_busy, m_ac};
            else if (!m_busy) begin
                exp_rd = m_mem[lin(m_ac)];
                m_ac   = m_step(m_ac, m_inc);
            end
        end else if (m_busy) begin
            m_ovr = 1;
        end else if (rs) begin
            m_mem[lin(m_ac)] = d;
            m_ac = m_step(m_ac, m_inc);
            if (m_shift) m_ds = (m_ds + (m_inc ? 1 : 39)) % 40;
        end else if (d >= 8'h80) begin
            if (m_legal(d[6:0])) m_ac = d[6:0];
            else                 m_err = 1;
        end else if (d >= 8'h40) begin
            m_err = 1;
        end else if (d >= 8'h20) begin
            m_eight = d[4]; m_two = d[3];
        end else if (d >= 8'h10) begin
            if (d[3]) m_ds = (m_ds + (d[2] ? 1 : 39)) % 40;
            else      m_ac = m_step(m_ac, d[2]);
        end else if (d >= 8'h08) begin
            m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
            m_inc = d[1]; m_shift = d[0];
        end else if (d >= 8'h02) begin
            m_ac = 7'd0; m_ds = 0;
        end else if (d == 8'h01) begin
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
            m_ac = 7'd0; m_inc = 1; m_ds = 0; m_busy = 1;
        end
    endtask

    // Status registers compared against the model on every quiet cycle.
    always @(negedge clk) begin
        if (cmp_en)
            check("status",
                  {10'd0, ac, disp_shift, disp_on, cursor_on, blink_on, inc_mode, shift_mode,
                   two_line, eight_bit, overrun, err_illegal},
                  {10'd0, m_ac, 6'(m_ds), m_disp, m_cur, m_blink, m_inc, m_shift,
                   m_two, m_eight, m_ovr, m_err});
    end

    // ---------------- bus driver ----------------
    // One bus cycle; returns at the negedge where its effects are first visible.
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d,
                        output logic v, output logic [7:0] got);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        v   = rd_valid;
        got = rd_data;
    endtask

    task automatic do_txn(input bit rs, input bit rw, input logic [7:0] d);
        logic [7:0] exp_rd, got;
        logic       v;
        cmp_en = 1'b0;
        model_txn(rs, rw, d, exp_rd);
        xfer(rs, rw, d, v, got);
        if (rw) begin
            check("rd_valid", 32'(v), 32'd1);
            check("rd_data", 32'(got), 32'(exp_rd));
            @(negedge clk);
            check("rd_valid_pulse", 32'(rd_valid), 32'd0);
        end else begin
            check("rd_valid_on_write", 32'(v), 32'd0);
        end
        cmp_en = 1'b1;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) do_txn(1'b1, 1'b0, s[i]);
    endtask

    // Called at a negedge; counts cycles with busy high, bounded.
    task automatic wait_fill(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic view_check(input int addr, input logic [7:0] exp, input string name);
        @(posedge clk); #1 view_addr = 7'(addr);
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(view_char), 32'(exp));
    endtask

    task automatic sweep_model();
        for (int i = 0; i < 80; i++) view_check(i, m_mem[i], $sformatf("view[%0d]", i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        string hello;
        hello = "Hello world!";
        rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
        view_addr = 7'd0;
        model_reset();

        // 1: reset values, 80-cycle fill, blank DDRAM
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ac", 32'(ac), 32'd0);
        check("rst_inc_mode", 32'(inc_mode), 32'd1);
        check("rst_eight_bit", 32'(eight_bit), 32'd1);
        check("rst_disp_on", 32'(disp_on), 32'd0);
        check("rst_flags", 32'({overrun, err_illegal}), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        wait_fill(n);
        check("fill_len_after_reset", 32'(n), 32'd80);
        m_busy = 0;
        cmp_en = 1'b1;
        sweep_model();
        view_check(80, 8'h20, "view_out_of_range_80");
        view_check(127, 8'h20, "view_out_of_range_127");

        // 2: function set, display control, entry mode
        do_txn(1'b0, 1'b0, 8'h38);
        do_txn(1'b0, 1'b0, 8'h0C);
        do_txn(1'b0, 1'b0, 8'h06);
        check("two_line", 32'(two_line), 32'd1);
        check("eight_bit", 32'(eight_bit), 32'd1);
        check("disp_on", 32'(disp_on), 32'd1);
        check("cursor_on", 32'(cursor_on), 32'd0);
        check("inc_mode", 32'(inc_mode), 32'd1);
        check("shift_mode", 32'(shift_mode), 32'd0);

        // 3: text on both lines
        do_txn(1'b0, 1'b0, 8'h80);
        write_str(hello);
        check("ac_after_hello", 32'(ac), 32'h0C);
        view_check(0, 8'h48, "hello_first");
        view_check(11, 8'h21, "hello_last");
        do_txn(1'b0, 1'b0, 8'hC0);
        write_str("2024");
        view_check(40, 8'h32, "line2_0");
        view_check(41, 8'h30, "line2_1");
        view_check(42, 8'h32, "line2_2");
        view_check(43, 8'h34, "line2_3");
        check("ac_after_2024", 32'(ac), 32'h44);

        // 4: AC wrap at end of each line
        do_txn(1'b0, 1'b0, 8'hA7);
        do_txn(1'b1, 1'b0, 8'h58);
        view_check(39, 8'h58, "view39_X");
        check("ac_wrap_line1", 32'(ac), 32'h40);
        do_txn(1'b0, 1'b0, 8'hE7);
        do_txn(1'b1, 1'b0, 8'h59);
        check("ac_wrap_line2", 32'(ac), 32'h00);
        view_check(79, 8'h59, "view79_Y");

        // Reads, shifts, cursor moves, entry shift
        do_txn(1'b0, 1'b0, 8'h80);
        do_txn(1'b1, 1'b1, 8'h00);
        check("ac_after_data_read", 32'(ac), 32'h01);
        do_txn(1'b0, 1'b1, 8'h00);
        do_txn(1'b0, 1'b0, 8'h1C);
        check("shift_right", 32'(disp_shift), 32'd1);
        do_txn(1'b0, 1'b0, 8'h18);
        do_txn(1'b0, 1'b0, 8'h18);
        check("shift_left_wrap", 32'(disp_shift), 32'd39);
        do_txn(1'b0, 1'b0, 8'h10);
        do_txn(1'b0, 1'b0, 8'h10);
        check("cursor_left_wrap", 32'(ac), 32'h67);
        do_txn(1'b0, 1'b0, 8'h07);
        do_txn(1'b1, 1'b0, 8'h5A);
        check("entry_shift_ac", 32'(ac), 32'h00);
        check("entry_shift_ds", 32'(disp_shift), 32'd0);
        do_txn(1'b0, 1'b0, 8'h06);
        do_txn(1'b0, 1'b0, 8'h00);
        sweep_model();

        // 5: clear display, then traffic during a fill
        do_txn(1'b0, 1'b0, 8'h01);
        wait_fill(n);
        check("fill_len_after_clear", 32'(n), 32'd80);
        m_busy = 0;
        check("ac_after_clear", 32'(ac), 32'h00);
        sweep_model();
        write_str("AB");
        do_txn(1'b0, 1'b0, 8'h01);
        do_txn(1'b1, 1'b0, 8'h51);
        do_txn(1'b0, 1'b1, 8'h00);
        do_txn(1'b1, 1'b1, 8'h00);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("ac_after_busy_read", 32'(ac), 32'h00);
        wait_fill(n);
        check("fill_ends", 32'(n < 300), 32'd1);
        m_busy = 0;
        sweep_model();

        // 6: illegal address, CGRAM, reset in the middle of a fill
        do_txn(1'b0, 1'b0, 8'h83);
        do_txn(1'b0, 1'b0, 8'hB0);
        check("err_illegal_set", 32'(err_illegal), 32'd1);
        check("ac_unchanged_illegal", 32'(ac), 32'h03);
        do_txn(1'b0, 1'b0, 8'h48);
        do_txn(1'b0, 1'b0, 8'h01);
        repeat (40) @(posedge clk);
        cmp_en = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_in_reset", 32'(busy), 32'd0);
        check("err_cleared", 32'(err_illegal), 32'd0);
        check("overrun_cleared", 32'(overrun), 32'd0);
        check("two_line_cleared", 32'(two_line), 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        wait_fill(n);
        check("fill_len_after_midfill_reset", 32'(n), 32'd80);
        m_busy = 0;
        cmp_en = 1'b1;
        sweep_model();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
